// File: rtl/dmem_responder.sv
// Data memory responder: single-port word array fronted by a 2-entry
// posted-write buffer with youngest-first store-to-load forwarding.
module dmem_responder #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mem_access_addr,
   input  logic [15:0] mem_write_data,
   input  logic        mem_write_en,
   input  logic        mem_read_en,
   output logic [15:0] mem_read_data,
   output logic        mem_stall,
   output logic        wbuf_empty
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [15:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_fa  [2];
   logic [15:0]       r_fd  [2];
   logic              r_head;
   logic              r_tail;
   logic [1:0]        r_cnt;

   logic [ADDR_W-1:0] w_addr;
   logic              w_full;
   logic              w_stall;
   logic              w_acc;
   logic              w_drain;
   logic              w_yng;
   logic              w_old;
   logic [15:0]       w_rdata;
   logic              w_unused;

   assign w_addr   = mem_access_addr[ADDR_W-1:0];
   assign w_unused = ^mem_access_addr[15:ADDR_W];
   assign w_full   = (r_cnt == 2'd2);
   assign w_stall  = mem_write_en & mem_read_en & w_full;
   assign w_acc    = mem_write_en & ~w_stall;
   // The array port belongs to the load whenever one is requested.
   assign w_drain  = (r_cnt != 2'd0) & ~mem_read_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head <= 1'b0;
         r_tail <= 1'b0;
         r_cnt  <= 2'd0;
      end else begin
         if (w_acc)   r_tail <= ~r_tail;
         if (w_drain) r_head <= ~r_head;
         unique case ({w_acc, w_drain})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_fa[r_tail] <= w_addr;
         r_fd[r_tail] <= mem_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_drain) r_mem[r_fa[r_head]] <= r_fd[r_head];
   end

   // Youngest entry sits just behind tail; the older one only when full.
   assign w_yng = ~r_tail;
   assign w_old = r_tail;

   always_comb begin
      w_rdata = r_mem[w_addr];
      if (w_full && r_fa[w_old] == w_addr)
         w_rdata = r_fd[w_old];
      if (r_cnt != 2'd0 && r_fa[w_yng] == w_addr)
         w_rdata = r_fd[w_yng];
   end

   assign mem_read_data = w_rdata;
   assign mem_stall     = w_stall;
   assign wbuf_empty    = (r_cnt == 2'd0);

endmodule
